// File: rtl/pipelined_memory_pkg.sv
// Shared types for the pipelined Avalon-MM agent memory and the interconnect.
package pipelined_memory_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    SLAVEERROR  = 2'b10,
    DECODEERROR = 2'b11
  } resp_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } mem_state_e;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  function automatic logic [15:0] err_sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'b0, inc};
    return sum[16] ? ERR_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/pipelined_memory_read_pipe.sv
// Fixed-latency read return pipe: shift register of {valid, resp, data}, stage 0 fed from the array.
module mem_read_pipe
  import pipelined_memory_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  resp_t         in_resp,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output resp_t         out_resp,
  output logic [DW-1:0] out_data
);

  typedef struct packed {
    logic          valid;
    resp_t         resp;
    logic [DW-1:0] data;
  } beat_t;

  beat_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: in_valid, resp: in_resp, data: in_data};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_resp  = stage_q[DEPTH-1].resp;
  assign out_data  = stage_q[DEPTH-1].data;

endmodule

// File: rtl/pipelined_memory.sv
// Avalon-MM agent memory with pipelined reads, write responses, error counter and hardware clear.
module pipelined_memory
  import pipelined_memory_pkg::*;
#(
  parameter logic [31:0] BASE             = 32'h0,
  parameter int unsigned SIZE             = 4096,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned READ_LATENCY     = 1,
  parameter bit          READ_ONLY        = 1'b0,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output resp_t                   response,
  output logic                    writeresponsevalid,
  output resp_t                   writeresponse,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [15:0]             err_count
);

  localparam int unsigned DB    = DATA_WIDTH / 8;
  localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned LB    = $clog2(DB);
  localparam int unsigned BEATS = SIZE / DB;
  localparam int unsigned PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [32:0] LO    = {1'b0, BASE};
  localparam logic [32:0] HI    = {1'b0, BASE} + 33'(SIZE);

  logic [7:0]            mem [SIZE];
  mem_state_e            state;
  logic [PW-1:0]         clr_ptr;
  logic [AW-1:0]         clr_base;
  logic                  accept;
  resp_t                 acc_resp;
  logic [AW-1:0]         offset;
  logic [DATA_WIDTH-1:0] rd_lanes;
  logic                  rd_valid;
  resp_t                 rd_resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            err_inc;

  // 33-bit compare so BASE+SIZE reaching 2^32 does not wrap.
  function automatic resp_t decode(input logic rd, input logic wr, input logic [31:0] a);
    logic [32:0] a33;
    a33 = {1'b0, a};
    if (rd && wr) return SLAVEERROR;
    if (!(a33 >= LO && a33 + 33'(DB) <= HI)) return DECODEERROR;
    if (!ALLOW_MISALIGNED && a[LB-1:0] != '0) return SLAVEERROR;
    if (wr && READ_ONLY) return SLAVEERROR;
    return OKAY;
  endfunction

  assign accept   = (read || write) && !waitrequest;
  assign acc_resp = decode(read, write, address);
  assign offset   = AW'(address - BASE);
  assign clr_base = AW'(clr_ptr) << LB;

  always_comb begin
    rd_lanes = '0;
    for (int unsigned i = 0; i < DB; i++) begin
      rd_lanes[8*i +: 8] = mem[offset + AW'(i)];
    end
  end

  assign rd_valid = accept && read;
  assign rd_resp  = rd_valid ? acc_resp : OKAY;
  assign rd_data  = (rd_valid && acc_resp == OKAY) ? rd_lanes : '0;

  // Array writes are suppressed under reset so an aborted clear leaves later beats intact.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        for (int unsigned i = 0; i < DB; i++) begin
          mem[clr_base + AW'(i)] <= '0;
        end
      end else if (accept && write && acc_resp == OKAY) begin
        for (int unsigned i = 0; i < DB; i++) begin
          if (byteenable[i]) mem[offset + AW'(i)] <= writedata[8*i +: 8];
        end
      end
    end
  end

  assign err_inc = {1'b0, readdatavalid && response != OKAY}
                 + {1'b0, writeresponsevalid && writeresponse != OKAY};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      clr_ptr            <= '0;
      waitrequest        <= 1'b0;
      clear_busy         <= 1'b0;
      writeresponsevalid <= 1'b0;
      writeresponse      <= OKAY;
      err_count          <= '0;
    end else begin
      writeresponsevalid <= accept && write;
      writeresponse      <= (accept && write) ? acc_resp : OKAY;
      err_count          <= err_sat_add(err_count, err_inc);
      case (state)
        IDLE: begin
          if (clear_req) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            waitrequest <= 1'b1;
            clear_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + PW'(1);
          if (clr_ptr == PW'(BEATS - 1)) begin
            state       <= IDLE;
            waitrequest <= 1'b0;
            clear_busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_read_pipe #(
    .DW    (DATA_WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid),
    .in_resp   (rd_resp),
    .in_data   (rd_data),
    .out_valid (readdatavalid),
    .out_resp  (response),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: three instances cover RL=1, RL=3 and READ_ONLY builds.
module tb_pipelined_memory;

  localparam int N = 3;
  localparam logic [1:0] R_OKAY = 2'b00;
  localparam logic [1:0] R_SLV  = 2'b10;
  localparam logic [1:0] R_DEC  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] address [N];
  logic        read [N];
  logic        write [N];
  logic [3:0]  be [N];
  logic [31:0] wdata [N];
  logic        clear_req [N];
  logic        waitreq [N];
  logic        rdv [N];
  logic        wrv [N];
  logic        busy [N];
  logic [31:0] rdata [N];
  logic [1:0]  resp [N];
  logic [1:0]  wresp [N];
  logic [15:0] errc [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_memory #(.BASE(32'h100), .SIZE(64), .DATA_WIDTH(32), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .address(address[0]), .read(read[0]), .write(write[0]),
    .byteenable(be[0]), .writedata(wdata[0]), .waitrequest(waitreq[0]), .readdata(rdata[0]),
    .readdatavalid(rdv[0]), .response(resp[0]), .writeresponsevalid(wrv[0]),
    .writeresponse(wresp[0]), .clear_req(clear_req[0]), .clear_busy(busy[0]), .err_count(errc[0]));

  pipelined_memory #(.BASE(32'h0), .SIZE(64), .DATA_WIDTH(32), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .address(address[1]), .read(read[1]), .write(write[1]),
    .byteenable(be[1]), .writedata(wdata[1]), .waitrequest(waitreq[1]), .readdata(rdata[1]),
    .readdatavalid(rdv[1]), .response(resp[1]), .writeresponsevalid(wrv[1]),
    .writeresponse(wresp[1]), .clear_req(clear_req[1]), .clear_busy(busy[1]), .err_count(errc[1]));

  pipelined_memory #(.BASE(32'h0), .SIZE(64), .DATA_WIDTH(32), .READ_LATENCY(1), .READ_ONLY(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .address(address[2]), .read(read[2]), .write(write[2]),
    .byteenable(be[2]), .writedata(wdata[2]), .waitrequest(waitreq[2]), .readdata(rdata[2]),
    .readdatavalid(rdv[2]), .response(resp[2]), .writeresponsevalid(wrv[2]),
    .writeresponse(wresp[2]), .clear_req(clear_req[2]), .clear_busy(busy[2]), .err_count(errc[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] v, output logic vld, output logic [1:0] r);
    address[d] = a; be[d] = b; wdata[d] = v; write[d] = 1'b1;
    tick();
    write[d] = 1'b0;
    vld = wrv[d];
    r = wresp[d];
  endtask

  task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] v,
                         output logic [1:0] r, output int lat);
    address[d] = a; read[d] = 1'b1;
    tick();
    read[d] = 1'b0;
    lat = 1;
    while (!rdv[d] && lat < 12) begin
      tick();
      lat++;
    end
    v = rdata[d];
    r = resp[d];
    checks++;
    if (!rdv[d]) begin
      errors++;
      $display("FAIL read_timeout: dut %0d addr %h got no readdatavalid within %0d cycles", d, a, lat);
    end
  endtask

  task automatic clear_and_wait(input int d, output int n);
    clear_req[d] = 1'b1;
    tick();
    clear_req[d] = 1'b0;
    n = 0;
    while (busy[d] && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      checks++;
      if ({waitreq[d], rdv[d], wrv[d], busy[d]} !== 4'b0 || rdata[d] !== 32'h0 || errc[d] !== 16'h0
          || resp[d] !== R_OKAY || wresp[d] !== R_OKAY)
        begin errors++; $display("FAIL reset_outputs: dut %0d wr/rdv/wrv/busy=%b%b%b%b rdata=%h err=%h, required all 0",
                                 d, waitreq[d], rdv[d], wrv[d], busy[d], rdata[d], errc[d]); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic v; logic [1:0] r; logic [31:0] dat; int lat;
    do_write(0, 32'h104, 4'hF, 32'hDEADBEEF, v, r);
    checks++;
    if (v !== 1'b1 || r !== R_OKAY) begin errors++; $display("FAIL t1_wresp: valid %b resp %b, required 1 00", v, r); end
    do_read(0, 32'h104, dat, r, lat);
    checks++;
    if (dat !== 32'hDEADBEEF || r !== R_OKAY || lat !== 1)
      begin errors++; $display("FAIL t1_read: data %h resp %b lat %0d, required deadbeef 00 1", dat, r, lat); end
  endtask

  task automatic test_back_to_back();
    logic v; logic [1:0] r; logic exp_v; logic [31:0] exp_d;
    do_write(1, 32'h0, 4'hF, 32'h11, v, r);
    do_write(1, 32'h4, 4'hF, 32'h22, v, r);
    do_write(1, 32'h8, 4'hF, 32'h33, v, r);
    address[1] = 32'h0; read[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) address[1] = 32'h4;
      else if (k == 2) address[1] = 32'h8;
      else read[1] = 1'b0;
      exp_v = (k >= 3 && k <= 5);
      exp_d = (k == 3) ? 32'h11 : (k == 4) ? 32'h22 : 32'h33;
      checks++;
      if (rdv[1] !== exp_v || (exp_v && (rdata[1] !== exp_d || resp[1] !== R_OKAY)))
        begin errors++; $display("FAIL t2_pipe cycle %0d: rdv %b data %h, required rdv %b data %h", k, rdv[1], rdata[1], exp_v, exp_d); end
    end
  endtask

  task automatic test_byteenable();
    logic v; logic [1:0] r; logic [31:0] dat; int lat;
    do_write(0, 32'h108, 4'hF, 32'hFFFFFFFF, v, r);
    do_write(0, 32'h108, 4'b0101, 32'hAABBCCDD, v, r);
    checks++;
    if (v !== 1'b1 || r !== R_OKAY) begin errors++; $display("FAIL t3_wresp: valid %b resp %b, required 1 00", v, r); end
    do_read(0, 32'h108, dat, r, lat);
    checks++;
    if (dat !== 32'hFFBBFFDD) begin errors++; $display("FAIL t3_lanes: got %h required ffbbffdd", dat); end
    do_write(0, 32'h108, 4'b0000, 32'h0, v, r);
    checks++;
    if (v !== 1'b1 || r !== R_OKAY) begin errors++; $display("FAIL t3_be0_resp: valid %b resp %b, required 1 00", v, r); end
    do_read(0, 32'h108, dat, r, lat);
    checks++;
    if (dat !== 32'hFFBBFFDD) begin errors++; $display("FAIL t3_be0_noop: got %h required ffbbffdd", dat); end
  endtask

  task automatic test_errors();
    logic v; logic [1:0] r; logic [31:0] dat; int lat;
    do_write(0, 32'h100, 4'hF, 32'h0BADF00D, v, r);
    do_read(0, 32'h13C, dat, r, lat);
    checks++;
    if (r !== R_OKAY) begin errors++; $display("FAIL t4_last_word: resp %b required 00", r); end
    do_read(0, 32'h140, dat, r, lat);
    checks++;
    if (r !== R_DEC || dat !== 32'h0) begin errors++; $display("FAIL t4_decode: resp %b data %h, required 11 0", r, dat); end
    tick();
    checks++;
    if (errc[0] !== 16'd1) begin errors++; $display("FAIL t4_err1: err_count %0d required 1", errc[0]); end
    do_write(0, 32'h102, 4'hF, 32'h12345678, v, r);
    checks++;
    if (v !== 1'b1 || r !== R_SLV) begin errors++; $display("FAIL t4_misaligned: valid %b resp %b, required 1 10", v, r); end
    tick();
    checks++;
    if (errc[0] !== 16'd2) begin errors++; $display("FAIL t4_err2: err_count %0d required 2", errc[0]); end
    do_read(0, 32'h100, dat, r, lat);
    checks++;
    if (dat !== 32'h0BADF00D) begin errors++; $display("FAIL t4_unchanged_lo: got %h required 0badf00d", dat); end
    do_read(0, 32'h104, dat, r, lat);
    checks++;
    if (dat !== 32'hDEADBEEF) begin errors++; $display("FAIL t4_unchanged_hi: got %h required deadbeef", dat); end
    do_read(0, 32'h0FC, dat, r, lat);
    tick();
    checks++;
    if (r !== R_DEC || errc[0] !== 16'd3)
      begin errors++; $display("FAIL t4_below_base: resp %b err %0d, required 11 3", r, errc[0]); end
  endtask

  task automatic test_clear();
    logic v; logic [1:0] r; logic [31:0] dat; int lat; int n; logic [31:0] exp_d;
    for (int k = 0; k < 16; k++) do_write(0, 32'h100 + 32'(4 * k), 4'hF, 32'hC0DE0000 | 32'(k), v, r);
    clear_req[0] = 1'b1;
    tick();
    clear_req[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 40) begin
      checks++;
      if (waitreq[0] !== 1'b1) begin errors++; $display("FAIL t5_waitreq: cycle %0d waitrequest %b required 1", n, waitreq[0]); end
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL t5_busy_len: busy for %0d cycles required 16", n); end
    for (int k = 0; k < 16; k++) begin
      do_read(0, 32'h100 + 32'(4 * k), dat, r, lat);
      checks++;
      if (dat !== 32'h0) begin errors++; $display("FAIL t5_zero word %0d: got %h required 0", k, dat); end
    end
    for (int k = 0; k < 16; k++) do_write(0, 32'h100 + 32'(4 * k), 4'hF, 32'hC0DE0000 | 32'(k), v, r);
    clear_req[0] = 1'b1;
    tick();
    clear_req[0] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy[0] !== 1'b0 || waitreq[0] !== 1'b0)
      begin errors++; $display("FAIL t5_abort: busy %b waitreq %b required 0 0", busy[0], waitreq[0]); end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      do_read(0, 32'h100 + 32'(4 * k), dat, r, lat);
      exp_d = (k < 5) ? 32'h0 : (32'hC0DE0000 | 32'(k));
      checks++;
      if (dat !== exp_d) begin errors++; $display("FAIL t5_partial word %0d: got %h required %h", k, dat, exp_d); end
    end
  endtask

  task automatic test_read_only_and_saturation();
    logic v; logic [1:0] r; logic [31:0] dat; int lat; int n;
    do_write(0, 32'h100, 4'hF, 32'h0BADF00D, v, r);
    address[0] = 32'h100; wdata[0] = 32'h55555555; be[0] = 4'hF; read[0] = 1'b1; write[0] = 1'b1;
    tick();
    read[0] = 1'b0; write[0] = 1'b0;
    checks++;
    if (wrv[0] !== 1'b1 || wresp[0] !== R_SLV)
      begin errors++; $display("FAIL t6_rw_wresp: valid %b resp %b required 1 10", wrv[0], wresp[0]); end
    checks++;
    if (rdv[0] !== 1'b1 || resp[0] !== R_SLV || rdata[0] !== 32'h0)
      begin errors++; $display("FAIL t6_rw_rresp: valid %b resp %b data %h required 1 10 0", rdv[0], resp[0], rdata[0]); end
    do_read(0, 32'h100, dat, r, lat);
    checks++;
    if (dat !== 32'h0BADF00D) begin errors++; $display("FAIL t6_rw_nowrite: got %h required 0badf00d", dat); end

    clear_and_wait(2, n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL t6_ro_clear: busy %0d cycles required 16", n); end
    do_write(2, 32'h0, 4'hF, 32'hFFFFFFFF, v, r);
    checks++;
    if (v !== 1'b1 || r !== R_SLV) begin errors++; $display("FAIL t6_ro_write: valid %b resp %b required 1 10", v, r); end
    do_read(2, 32'h0, dat, r, lat);
    tick();
    checks++;
    if (dat !== 32'h0 || r !== R_OKAY || errc[2] !== 16'd1)
      begin errors++; $display("FAIL t6_ro_read: data %h resp %b err %0d required 0 00 1", dat, r, errc[2]); end

    address[2] = 32'h0; be[2] = 4'hF; read[2] = 1'b1; write[2] = 1'b1;
    repeat (32766) tick();
    read[2] = 1'b0; write[2] = 1'b0;
    repeat (2) tick();
    checks++;
    if (errc[2] !== 16'd65533) begin errors++; $display("FAIL t6_err_double: err_count %0d required 65533", errc[2]); end
    do_write(2, 32'h0, 4'hF, 32'h0, v, r);
    tick();
    checks++;
    if (errc[2] !== 16'd65534) begin errors++; $display("FAIL t6_err_single: err_count %0d required 65534", errc[2]); end
    read[2] = 1'b1; write[2] = 1'b1;
    tick();
    read[2] = 1'b0; write[2] = 1'b0;
    repeat (2) tick();
    checks++;
    if (errc[2] !== 16'hFFFF) begin errors++; $display("FAIL t6_sat_double: err_count %h required ffff", errc[2]); end
    do_read(2, 32'h1000, dat, r, lat);
    repeat (2) tick();
    checks++;
    if (errc[2] !== 16'hFFFF || r !== R_DEC)
      begin errors++; $display("FAIL t6_sat_hold: err_count %h resp %b required ffff 11", errc[2], r); end
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      address[d] = '0; read[d] = 1'b0; write[d] = 1'b0; be[d] = '0; wdata[d] = '0; clear_req[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_byteenable();
    test_errors();
    test_clear();
    test_read_only_and_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
